// File: rtl/mux8_tdm_pkg.sv
// rtl/mux8_tdm_pkg.sv - shared types and sizes for the eight-lane TDM transmitter
package mux8_tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;
  localparam int HOLD_MAX  = 16;
  localparam int HOLD_W    = $clog2(HOLD_MAX);

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - per-slot hold counter and lane select counter
module tdm_slot_counter
  import mux8_tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [SEL_W-1:0] sel,
  output logic             slot_end,
  output logic             last_slot
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  assign slot_end  = en && (hold_q == HOLD_LAST);
  assign last_slot = slot_end && (sel_q == SEL_W'(NUM_LANES - 1));
  assign sel       = sel_q;

  // sel wraps 7->0 naturally on the final slot end, which is the frame boundary
  always_comb begin
    hold_d = hold_q;
    sel_d  = sel_q;
    if (clr) begin
      hold_d = '0;
      sel_d  = '0;
    end else if (slot_end) begin
      hold_d = '0;
      sel_d  = sel_q + SEL_W'(1);
    end else if (en) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      hold_q <= '0;
      sel_q  <= '0;
    end else begin
      hold_q <= hold_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/mux8_tdm.sv
// rtl/mux8_tdm.sv - eight-lane time-division multiplexer with snapshot framing
module mux8_tdm
  import mux8_tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             loop,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             h,
  output logic             out,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   snap_q, snap_d;
  logic                   done_q, done_d;
  logic [NUM_LANES-1:0]   lanes;
  logic                   slot_end;
  logic                   last_slot;

  assign lanes = {h, g, f, e, d, c, b, a};

  tdm_slot_counter #(.HOLD(HOLD)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == SEND),
    .clr       (state_q == IDLE),
    .sel       (sel),
    .slot_end  (slot_end),
    .last_slot (last_slot)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = lanes;
          state_d = SEND;
        end
      end
      SEND: begin
        // start is deliberately ignored here; only frame completion leaves SEND
        if (slot_end && last_slot) begin
          done_d = 1'b1;
          if (loop) snap_d = lanes;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  assign valid = (state_q == SEND);
  assign busy  = (state_q == SEND);
  assign out   = (state_q == SEND) ? snap_q[sel] : 1'b0;
  assign done  = done_q;

endmodule

// File: tb/tb_mux8_tdm.sv
// tb/tb_mux8_tdm.sv - directed self-checking bench for mux8_tdm
module tb_mux8_tdm;

  logic       clk = 1'b1;
  logic       rst;
  logic       start1, start3, loop1, loop3;
  logic [7:0] ln;

  logic       out1, valid1, busy1, done1;
  logic [2:0] sel1;
  logic       out3, valid3, busy3, done3;
  logic [2:0] sel3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux8_tdm #(.HOLD(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .loop(loop1),
    .a(ln[0]), .b(ln[1]), .c(ln[2]), .d(ln[3]),
    .e(ln[4]), .f(ln[5]), .g(ln[6]), .h(ln[7]),
    .out(out1), .sel(sel1), .valid(valid1), .busy(busy1), .done(done1)
  );

  mux8_tdm #(.HOLD(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .loop(loop3),
    .a(ln[0]), .b(ln[1]), .c(ln[2]), .d(ln[3]),
    .e(ln[4]), .f(ln[5]), .g(ln[6]), .h(ln[7]),
    .out(out3), .sel(sel3), .valid(valid3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic [2:0] s,
                      input logic v, input logic b, input logic dn);
    chk({tag, ".out"},   {7'd0, out1},   {7'd0, o});
    chk({tag, ".sel"},   {5'd0, sel1},   {5'd0, s});
    chk({tag, ".valid"}, {7'd0, valid1}, {7'd0, v});
    chk({tag, ".busy"},  {7'd0, busy1},  {7'd0, b});
    chk({tag, ".done"},  {7'd0, done1},  {7'd0, dn});
  endtask

  // lanes a..h = 1,0,1,1,0,0,1,0
  logic pat_4d [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // 8'hA5 from lane a upward
  logic pat_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; loop1 = 1'b0; loop3 = 1'b0; ln = 8'h00;

    tick(); chk1("rst0", 0, 0, 0, 0, 0);
    tick(); chk1("rst1", 0, 0, 0, 0, 0);
    chk("rst.u3.valid", {7'd0, valid3}, 8'd0);
    rst = 1'b0;
    tick(); chk1("idle", 0, 0, 0, 0, 0);

    // one-shot, HOLD=1
    ln = 8'h4D; start1 = 1'b1;
    tick(); chk1("os.s0", pat_4d[0], 3'd0, 1, 1, 0);
    start1 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick(); chk1($sformatf("os.s%0d", i), pat_4d[i], 3'(i), 1, 1, 0);
    end
    tick(); chk1("os.done", 0, 0, 0, 0, 1);
    tick(); chk1("os.after", 0, 0, 0, 0, 0);

    // snapshot held against lane changes and ignored start
    ln = 8'hFF; start1 = 1'b1;
    tick(); chk1("snap.s0", 1, 3'd0, 1, 1, 0);
    start1 = 1'b0; ln = 8'h00;
    for (int i = 1; i < 8; i++) begin
      start1 = (i == 3 || i == 4);
      tick(); chk1($sformatf("snap.s%0d", i), 1, 3'(i), 1, 1, 0);
    end
    start1 = 1'b0;
    tick(); chk1("snap.done", 0, 0, 0, 0, 1);
    tick(); chk1("snap.idle", 0, 0, 0, 0, 0);

    // HOLD=3 looping, then drop loop for a final frame
    ln = 8'hA5; start3 = 1'b1; loop3 = 1'b1;
    tick();
    chk("lp.s0.sel", {5'd0, sel3}, 8'd0);
    chk("lp.s0.out", {7'd0, out3}, {7'd0, pat_a5[0]});
    chk("lp.s0.valid", {7'd0, valid3}, 8'd1);
    start3 = 1'b0;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k < 72) begin
        chk($sformatf("lp.k%0d.sel", k), {5'd0, sel3}, 8'((k % 24) / 3));
        chk($sformatf("lp.k%0d.out", k), {7'd0, out3}, {7'd0, pat_a5[(k % 24) / 3]});
        chk($sformatf("lp.k%0d.valid", k), {7'd0, valid3}, 8'd1);
        chk($sformatf("lp.k%0d.busy", k), {7'd0, busy3}, 8'd1);
      end else begin
        chk("lp.end.sel", {5'd0, sel3}, 8'd0);
        chk("lp.end.out", {7'd0, out3}, 8'd0);
        chk("lp.end.valid", {7'd0, valid3}, 8'd0);
        chk("lp.end.busy", {7'd0, busy3}, 8'd0);
      end
      chk($sformatf("lp.k%0d.done", k), {7'd0, done3}, {7'd0, (k % 24) == 0});
      if (k == 48) loop3 = 1'b0;
    end
    tick(); chk("lp.idle.done", {7'd0, done3}, 8'd0);

    // reset mid-frame at slot 4
    ln = 8'hFF; start1 = 1'b1;
    tick(); start1 = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk1("rm.s4", 1, 3'd4, 1, 1, 0);
    rst = 1'b1;
    tick(); chk1("rm.rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk1($sformatf("rm.post%0d", i), 0, 0, 0, 0, 0);
    end

    // back-to-back one-shot with start held high
    ln = 8'h4D; start1 = 1'b1;
    tick(); chk1("bb.f0.s0", pat_4d[0], 3'd0, 1, 1, 0);
    for (int i = 1; i < 8; i++) tick();
    chk1("bb.f0.s7", pat_4d[7], 3'd7, 1, 1, 0);
    tick(); chk1("bb.f0.done", 0, 0, 0, 0, 1);
    tick(); chk1("bb.f1.s0", pat_4d[0], 3'd0, 1, 1, 0);
    start1 = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick(); chk1("bb.f1.done", 0, 0, 0, 0, 1);
    tick(); chk1("bb.idle", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_tdm.md
# mux8_tdm

Time-division multiplexer that collects eight single-bit lanes (a..h) into one serial stream tagged with a 3-bit lane select, forming the transmit end of the lane-distribution path whose receive end is the eight-way demultiplexer. A frame snapshot of all eight lanes is taken on start and emitted one lane per slot, so `out`/`sel` can drive the demultiplexer's `in`/`sel` directly. Supports one-shot and continuous (looping) framing.

## Interface

- HOLD, 1, falling edges each slot is held on `out`/`sel`; legal range 1..16.
- clk  in  1  clock; all state changes on the falling edge of clk.
- rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk.
- start  in  1  frame request; sampled only in IDLE.
- loop  in  1  continuous mode; sampled at the end of slot 7.
- a, b, c, d, e, f, g, h  in  1 each  lane inputs; a = lane 0 … h = lane 7.
- out  out  1  serialized lane bit for the current slot.
- sel  out  3  index of the lane currently on `out`.
- valid  out  1  high while `out`/`sel` carry a frame slot.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.

## Operation

- Reset values: out=0, sel=3'b000, valid=0, busy=0, done=0; state IDLE; snapshot and hold counter cleared.
- States: IDLE, SEND.
- IDLE: start=1 at a falling edge → capture {h,g,f,e,d,c,b,a} into an 8-bit snapshot; sel=0; out=snapshot[0]; valid=1; busy=1; hold count=0; go to SEND. With start=0, outputs keep reset values (done clears after one cycle).
- SEND: hold count increments each edge. When hold count reaches HOLD-1, the slot ends: count → 0, sel → sel+1, out → snapshot[sel+1].
- End of slot 7:
  - loop=1: done=1 for one cycle; recapture the lanes; sel=0, out=new snapshot[0]; valid/busy stay high; no idle gap.
  - loop=0: done=1, valid=0, busy=0, out=0, sel=0; go to IDLE.
- Lane inputs changing mid-frame do not affect `out` (snapshot only).
- start while in SEND is ignored, whether or not loop is set; the frame is not restarted.
- rst=1 in any state has priority over everything: abort the frame, restore reset values, and do not pulse done.
- sel never exceeds 7; it wraps 7→0 only through frame completion.

## Timing

- Latency: the first slot is on `out` the same falling edge on which start is sampled high.
- Frame length: 8×HOLD falling edges from the first slot to the done edge.
- done is asserted on the edge the last slot ends, concurrent with valid falling (loop=0) or with sel returning to 0 (loop=1).
- In one-shot mode, back-to-back frames have a minimum 1-cycle gap: start is sampled in IDLE on the edge after done.
- rst takes effect at the first falling edge where it is sampled high; outputs hold reset values while rst stays high.

## Structure

- Package mux8_tdm_pkg holds:
  - the state enum (IDLE, SEND);
  - NUM_LANES=8;
  - SEL_W=3;
  - HOLD_MAX=16.
- One sub-module, tdm_slot_counter, with ports clk, rst, en, and clr. It contains the hold counter and the sel counter, and outputs slot_end and last_slot (slot_end && sel==7).
- The top level contains the FSM, the snapshot register, and the output mux.

## Test plan

- Reset then idle: rst=1 for 2 edges, start=0 → out=0, sel=0, valid=0, busy=0, done=0 throughout.
- One-shot, HOLD=1: lanes a..h=1,0,1,1,0,0,1,0, start for one edge → `out` = 1,0,1,1,0,0,1,0 with sel=0..7 on consecutive edges; done=1 on the 8th edge; then valid=0.
- Snapshot/ignore: start a frame with all lanes=1, drive all lanes 0 and pulse start at slot 3 → `out` stays 1 for all 8 slots, with no restart.
- HOLD=3, loop=1: lanes=8'hA5 → each sel is held 3 edges; done pulses every 24 edges; sel goes 7→0 with no gap and valid stays 1.
- Reset mid-frame: rst at slot 4 → the next edge gives out=0, sel=0, valid=0, busy=0, and done is never asserted.
- Back-to-back one-shot with start held high → a 1-cycle idle gap between done and the next sel=0 slot.
